detect_event_logger: RTL and testbench
======================================

# detect_event_logger

Downstream stage of the overlapping sequence detector. Each cycle it sees `detected` high, it captures a timestamp and the 4-bit `data_in` nibble into a small FIFO. The FIFO drains through a valid/ready stream port. The block also keeps saturating counts of accepted and dropped events for status readout.

## Interface
- `TS_W`, default 16: timestamp counter width.
- `DEPTH`, default 8: FIFO entries; power of two, at least 2.
- `CNT_W`, default 16: event counter width.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `enable`  in  1  event capture enable; the timestamp runs regardless.
- `detected`  in  1  detector output; each cycle it is high counts as one event.
- `data_in`  in  4  nibble present on the detector input, logged with the event.
- `out_valid`  out  1  FIFO head is valid.
- `out_ready`  in  1  consumer accepts the head this cycle.
- `out_data`  out  TS_W+4  {timestamp[TS_W-1:0], nibble[3:0]} of the FIFO head.
- `event_count`  out  CNT_W  accepted events; saturating.
- `drop_count`  out  8  events lost to a full FIFO; saturating at 255.
- `overflow`  out  1  sticky; set on the first drop.
- `fifo_level`  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.

## Operation
- **Timestamp:** `ts` is a free-running TS_W-bit counter.
  - It increments every cycle and wraps from 2^TS_W-1 to 0.
  - It is not gated by `enable`.
- **Event:** an event occurs when `enable`=1 and `detected`=1 at a rising edge.
  - Back-to-back high cycles are separate events; overlapping detections must all be logged.
- **Push:** on an event, write {`ts`, `data_in`} at `wr_ptr`, using the pre-increment `ts` value of that edge.
- **Pop:** when `out_valid`=1 and `out_ready`=1, advance `rd_ptr`.
- **FIFO:** circular buffer with pointers of $clog2(DEPTH)+1 bits; the MSB distinguishes full from empty.
  - empty: pointers are equal.
  - full: MSBs differ and the rest are equal.
- **Full + event, no pop:** the event is dropped.
  - `drop_count` increments (saturating) and `overflow` is set.
  - `event_count` is unchanged.
- **Full + event + pop in the same cycle:** the push is accepted. There is no drop and the level stays at DEPTH.
- **Empty + event + `out_ready`=1:** no bypass. The entry is written and becomes valid in the next cycle.
- **Accepted push:** `event_count` increments and holds at 2^CNT_W-1.
- `enable`=0 suppresses push, counting and dropping. Pops continue.
- `overflow` clears only on `reset`.
- **Reset:** synchronous and active-high; takes priority over any simultaneous event or pop. Mid-operation reset discards all FIFO contents.
  - Cleared to 0: `ts`, `wr_ptr`, `rd_ptr`, `event_count`, `drop_count`, `overflow`.
  - Outputs after reset: `out_valid`=0, `fifo_level`=0.
  - `out_data` is don't-care while `out_valid`=0.

## Timing
- Push latency: an event sampled at edge N gives `out_valid`=1 and the correct `out_data` in the cycle after edge N.
- `out_data` is a combinational read of registered storage at `rd_ptr` (first-word fall-through). No combinational path from `detected` to any output.
- `out_valid` is derived from the pointer registers only. It is independent of `out_ready`.
- `out_data` and `out_valid` stay stable while `out_valid`=1 and `out_ready`=0.
- Status outputs (`event_count`, `drop_count`, `overflow`, `fifo_level`) update at the same edge as the push or pop that causes them.
- Throughput: one push and one pop per cycle, sustained.

## Test plan
- **Reset:** hold `reset` for 2 cycles with `detected`=1.
  - Required: every output is 0 and no entry is logged.
  - After release, `ts` reads 0 at the first edge.
- **Single event:** `enable`=1; pulse `detected`=1 with `data_in`=4'b1011 at the edge where `ts`=5.
  - Required next cycle: `out_valid`=1, `out_data`={16'd5, 4'hB}, `event_count`=1, `fifo_level`=1.
  - Assert `out_ready` for one cycle. Required: `out_valid`=0.
- **Overlapping run:** `detected` high for 3 consecutive cycles, `out_ready`=0.
  - Required: 3 entries with timestamps t, t+1, t+2, `fifo_level`=3, `event_count`=3.
- **Overflow:** DEPTH=8, `out_ready`=0, `detected` high for 10 cycles.
  - Required: `fifo_level`=8, `event_count`=8, `drop_count`=2, `overflow`=1.
  - Then drain all 8 entries. Required: the oldest 8 come out in order and `overflow` stays 1.
- **Full with simultaneous pop:** fill to 8, then hold `detected`=1 and `out_ready`=1 for 4 cycles.
  - Required: `drop_count` unchanged, `fifo_level`=8 throughout, popped entries in FIFO order.
- **Timestamp wrap and mid-operation reset:** TS_W=4, with events at `ts`=15 and `ts`=0.
  - Required: entries carry timestamps 15 then 0.
  - Assert `reset` with 2 entries queued. Required: `fifo_level`=0 and `out_valid`=0 on the following cycle.

Source files
------------

// File: rtl/detect_event_logger.sv
// rtl/detect_event_logger.sv - timestamped event FIFO with saturating accept/drop counters
module detect_event_logger #(
  parameter int TS_W  = 16,
  parameter int DEPTH = 8,
  parameter int CNT_W = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic                    detected,
  input  logic [3:0]              data_in,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [TS_W+3:0]         out_data,
  output logic [CNT_W-1:0]        event_count,
  output logic [7:0]              drop_count,
  output logic                    overflow,
  output logic [$clog2(DEPTH):0]  fifo_level
);
  localparam int AW = $clog2(DEPTH);

  logic [TS_W-1:0]  ts;
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [TS_W+3:0]  mem [DEPTH];

  logic empty;
  logic full;
  logic evt;
  logic pop;
  logic push;
  logic drop;

  // Extra pointer MSB tells a wrapped (full) buffer apart from an empty one.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign evt   = enable && detected;
  assign pop   = out_valid && out_ready;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign push  = evt && (!full || pop);
  assign drop  = evt && full && !pop;

  assign out_valid  = !empty;
  assign out_data   = mem[rd_ptr[AW-1:0]];
  assign fifo_level = wr_ptr - rd_ptr;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr[AW-1:0]] <= {ts, data_in};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ts          <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      event_count <= '0;
      drop_count  <= '0;
      overflow    <= 1'b0;
    end else begin
      ts <= ts + TS_W'(1);
      if (push) begin
        wr_ptr <= wr_ptr + (AW+1)'(1);
        if (event_count != {CNT_W{1'b1}}) begin
          event_count <= event_count + CNT_W'(1);
        end
      end
      if (pop) begin
        rd_ptr <= rd_ptr + (AW+1)'(1);
      end
      if (drop) begin
        overflow <= 1'b1;
        if (drop_count != 8'hFF) begin
          drop_count <= drop_count + 8'd1;
        end
      end
    end
  end
endmodule

// File: tb/tb_detect_event_logger.sv
// tb/tb_detect_event_logger.sv - randomized and directed bench against a queue-based reference model
`timescale 1ns/1ps
module tb_detect_event_logger;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic        detected = 1'b0;
  logic [3:0]  data_in = 4'h0;
  logic        out_ready = 1'b0;

  logic        out_valid;
  logic [19:0] out_data;
  logic [15:0] event_count;
  logic [7:0]  drop_count;
  logic        overflow;
  logic [3:0]  fifo_level;

  logic        out_valid4;
  logic [7:0]  out_data4;
  logic [15:0] event_count4;
  logic [7:0]  drop_count4;
  logic        overflow4;
  logic [3:0]  fifo_level4;

  int checks = 0;
  int errors = 0;

  // Reference model: queue of {ts16, nibble}, free-running cycle count, counters.
  logic [19:0] mq[$];
  int          mts = 0;
  int          mec = 0;
  int          mdc = 0;
  bit          movf = 0;

  always #5 clk = ~clk;

  detect_event_logger #(.TS_W(16), .DEPTH(8), .CNT_W(16)) u_dut (
    .clk(clk), .reset(reset), .enable(enable), .detected(detected), .data_in(data_in),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .event_count(event_count), .drop_count(drop_count), .overflow(overflow),
    .fifo_level(fifo_level)
  );

  detect_event_logger #(.TS_W(4), .DEPTH(8), .CNT_W(16)) u_dut4 (
    .clk(clk), .reset(reset), .enable(enable), .detected(detected), .data_in(data_in),
    .out_valid(out_valid4), .out_ready(out_ready), .out_data(out_data4),
    .event_count(event_count4), .drop_count(drop_count4), .overflow(overflow4),
    .fifo_level(fifo_level4)
  );

  task automatic cycle(input logic rst, input logic en, input logic det,
                       input logic [3:0] d, input logic rdy);
    bit ev;
    bit full;
    bit pop;
    bit push;
    logic [31:0] t;
    reset = rst; enable = en; detected = det; data_in = d; out_ready = rdy;
    @(posedge clk);
    if (rst) begin
      mq.delete(); mts = 0; mec = 0; mdc = 0; movf = 0;
    end else begin
      ev   = en && det;
      full = (mq.size() == 8);
      pop  = (mq.size() != 0) && rdy;
      push = ev && (!full || pop);
      if (pop) void'(mq.pop_front());
      t = mts;
      if (push) begin
        mq.push_back({t[15:0], d});
        if (mec < 65535) mec++;
      end else if (ev) begin
        if (mdc < 255) mdc++;
        movf = 1;
      end
      mts++;
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    cycle(1, 1, 1, 4'hF, 1);
    cycle(1, 1, 1, 4'hF, 1);
    checks++;
    if ({out_valid, fifo_level, event_count, drop_count, overflow, out_valid4} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: valid=%0b level=%0d ev=%0d drop=%0d ovf=%0b expected all 0",
               out_valid, fifo_level, event_count, drop_count, overflow);
    end
    cycle(0, 1, 1, 4'hA, 0);
    checks++;
    if (out_data !== {16'd0, 4'hA} || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL reset_first_ts: got valid=%0b data=%h expected valid=1 data=%h",
               out_valid, out_data, {16'd0, 4'hA});
    end
  endtask

  task automatic test_single_event();
    cycle(1, 0, 0, 0, 0);
    while (mts < 5) cycle(0, 1, 0, 4'h0, 0);
    cycle(0, 1, 1, 4'b1011, 0);
    checks++;
    if (out_valid !== 1'b1 || out_data !== {16'd5, 4'hB} || event_count !== 16'd1 || fifo_level !== 4'd1) begin
      errors++;
      $display("FAIL single_event: valid=%0b data=%h ev=%0d level=%0d expected 1 %h 1 1",
               out_valid, out_data, event_count, fifo_level, {16'd5, 4'hB});
    end
    cycle(0, 1, 0, 4'h0, 1);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_pop: valid=%0b expected 0", out_valid);
    end
  endtask

  task automatic test_overlap();
    int t0;
    logic [3:0] nib [3];
    logic [31:0] t;
    cycle(1, 0, 0, 0, 0);
    cycle(0, 1, 0, 0, 0);
    cycle(0, 1, 0, 0, 0);
    t0 = mts;
    for (int i = 0; i < 3; i++) begin
      nib[i] = 4'($urandom);
      cycle(0, 1, 1, nib[i], 0);
    end
    checks++;
    if (fifo_level !== 4'd3 || event_count !== 16'd3) begin
      errors++;
      $display("FAIL overlap_counts: level=%0d ev=%0d expected 3 3", fifo_level, event_count);
    end
    for (int i = 0; i < 3; i++) begin
      t = t0 + i;
      checks++;
      if (out_data !== {t[15:0], nib[i]}) begin
        errors++;
        $display("FAIL overlap_entry%0d: got %h expected %h", i, out_data, {t[15:0], nib[i]});
      end
      cycle(0, 1, 0, 0, 1);
    end
  endtask

  task automatic test_overflow();
    logic [3:0] nib [10];
    cycle(1, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) begin
      nib[i] = 4'($urandom);
      cycle(0, 1, 1, nib[i], 0);
    end
    checks++;
    if (fifo_level !== 4'd8 || event_count !== 16'd8 || drop_count !== 8'd2 || overflow !== 1'b1) begin
      errors++;
      $display("FAIL overflow_status: level=%0d ev=%0d drop=%0d ovf=%0b expected 8 8 2 1",
               fifo_level, event_count, drop_count, overflow);
    end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (out_valid !== 1'b1 || out_data !== {16'(i), nib[i]}) begin
        errors++;
        $display("FAIL overflow_drain%0d: valid=%0b data=%h expected %h", i, out_valid, out_data, {16'(i), nib[i]});
      end
      cycle(0, 1, 0, 0, 1);
    end
    checks++;
    if (out_valid !== 1'b0 || overflow !== 1'b1 || drop_count !== 8'd2) begin
      errors++;
      $display("FAIL overflow_sticky: valid=%0b ovf=%0b drop=%0d expected 0 1 2", out_valid, overflow, drop_count);
    end
  endtask

  task automatic test_full_pop();
    logic [19:0] exp;
    cycle(1, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) cycle(0, 1, 1, 4'($urandom), 0);
    for (int i = 0; i < 4; i++) begin
      exp = mq[0];
      checks++;
      if (out_data !== exp) begin
        errors++;
        $display("FAIL fullpop_order%0d: got %h expected %h", i, out_data, exp);
      end
      cycle(0, 1, 1, 4'($urandom), 1);
      checks++;
      if (fifo_level !== 4'd8 || drop_count !== 8'd0 || overflow !== 1'b0) begin
        errors++;
        $display("FAIL fullpop_level%0d: level=%0d drop=%0d ovf=%0b expected 8 0 0",
                 i, fifo_level, drop_count, overflow);
      end
    end
  endtask

  task automatic test_drop_saturation();
    cycle(1, 0, 0, 0, 0);
    for (int i = 0; i < 270; i++) cycle(0, 1, 1, 4'h3, 0);
    checks++;
    if (drop_count !== 8'd255 || event_count !== 16'd8 || fifo_level !== 4'd8) begin
      errors++;
      $display("FAIL drop_saturation: drop=%0d ev=%0d level=%0d expected 255 8 8",
               drop_count, event_count, fifo_level);
    end
  endtask

  task automatic test_ts_wrap_and_reset();
    cycle(1, 0, 0, 0, 0);
    while (mts < 15) cycle(0, 1, 0, 0, 0);
    cycle(0, 1, 1, 4'h6, 0);
    cycle(0, 1, 1, 4'h9, 0);
    checks++;
    if (out_data4 !== {4'hF, 4'h6}) begin
      errors++;
      $display("FAIL wrap_ts15: got %h expected %h", out_data4, {4'hF, 4'h6});
    end
    cycle(0, 1, 1, 4'h2, 1);
    checks++;
    if (out_data4 !== {4'h0, 4'h9} || fifo_level4 !== 4'd2) begin
      errors++;
      $display("FAIL wrap_ts0: got %h level=%0d expected %h level=2", out_data4, fifo_level4, {4'h0, 4'h9});
    end
    cycle(1, 1, 1, 4'h5, 1);
    checks++;
    if (fifo_level !== 4'd0 || out_valid !== 1'b0 || fifo_level4 !== 4'd0 || out_valid4 !== 1'b0) begin
      errors++;
      $display("FAIL midop_reset: level=%0d valid=%0b level4=%0d valid4=%0b expected 0",
               fifo_level, out_valid, fifo_level4, out_valid4);
    end
  endtask

  task automatic test_random();
    cycle(1, 0, 0, 0, 0);
    for (int i = 0; i < 400; i++) begin
      cycle(($urandom_range(0, 99) == 0), ($urandom_range(0, 9) != 0), $urandom_range(0, 1),
            4'($urandom), ($urandom_range(0, 2) == 0));
      checks++;
      if (out_valid !== (mq.size() != 0) || fifo_level !== 4'(mq.size())) begin
        errors++;
        $display("FAIL rand_level@%0d: valid=%0b level=%0d expected level=%0d", i, out_valid, fifo_level, mq.size());
      end
      checks++;
      if (event_count !== 16'(mec) || drop_count !== 8'(mdc) || overflow !== movf) begin
        errors++;
        $display("FAIL rand_counts@%0d: ev=%0d drop=%0d ovf=%0b expected %0d %0d %0b",
                 i, event_count, drop_count, overflow, mec, mdc, movf);
      end
      if (mq.size() != 0) begin
        checks++;
        if (out_data !== mq[0] || out_data4 !== mq[0][7:0]) begin
          errors++;
          $display("FAIL rand_data@%0d: got %h/%h expected %h/%h", i, out_data, out_data4, mq[0], mq[0][7:0]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_event();
    test_overlap();
    test_overflow();
    test_full_pop();
    test_drop_saturation();
    test_ts_wrap_and_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
